// File: rtl/ila_pkg.sv
// ============================================================================
// ila_pkg : shared FSM encoding and depth helper for the ILA capture buffer
// Revision : 1.0
// ============================================================================
`default_nettype none

package ila_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRE       = 3'd1,
    ST_WAIT_TRIG = 3'd2,
    ST_POST      = 3'd3,
    ST_DONE      = 3'd4
  } ila_state_e;

  function automatic int unsigned ila_depth(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ila_sdp_ram.sv
// ============================================================================
// ila_sdp_ram : single-clock simple dual-address RAM, registered read
// Revision : 1.0
// ============================================================================
`default_nettype none

module ila_sdp_ram
  import ila_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  // No reset on the array or read register so the tools map this onto BRAM.
  logic [DATA_WIDTH-1:0] mem_q [0:ila_depth(ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/ila_capture_buffer.sv
// ============================================================================
// ila_capture_buffer : trigger-aware circular sample store with pre-trigger
//                      window and trigger-relative readout
// Revision : 1.0
// ============================================================================
`default_nettype none

module ila_capture_buffer
  import ila_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  arm,
  input  logic [ADDR_WIDTH-1:0] pretrig_cnt,
  input  logic                  sample_en,
  input  logic                  trigger,
  input  logic [DATA_WIDTH-1:0] di,
  output logic                  busy,
  output logic                  wait_trig,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] trig_addr,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] do_o,
  output logic                  do_valid
);

  localparam logic [ADDR_WIDTH-1:0] c_LAST_IDX = '1;
  localparam logic [ADDR_WIDTH-1:0] c_ONE      = ADDR_WIDTH'(1);

  ila_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] s_di_q;
  logic                  s_trig_q;
  logic                  s_en_q;
  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] pre_q, pre_d;
  logic [ADDR_WIDTH-1:0] post_q, post_d;
  logic [ADDR_WIDTH-1:0] start_q, start_d;
  logic [ADDR_WIDTH-1:0] trig_addr_q, trig_addr_d;
  logic                  rd_valid_q;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] rd_phys;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign wr_en   = s_en_q && ((state_q == ST_PRE) || (state_q == ST_WAIT_TRIG) ||
                              (state_q == ST_POST));
  assign rd_phys = start_q + rd_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      s_di_q      <= '0;
      s_trig_q    <= 1'b0;
      s_en_q      <= 1'b0;
      wptr_q      <= '0;
      cnt_q       <= '0;
      pre_q       <= '0;
      post_q      <= '0;
      start_q     <= '0;
      trig_addr_q <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_di_q      <= di;
      s_trig_q    <= trigger;
      s_en_q      <= sample_en;
      wptr_q      <= wptr_d;
      cnt_q       <= cnt_d;
      pre_q       <= pre_d;
      post_q      <= post_d;
      start_q     <= start_d;
      trig_addr_q <= trig_addr_d;
      rd_valid_q  <= rd_en;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pre_d       = pre_q;
    post_d      = post_q;
    start_d     = start_q;
    trig_addr_d = trig_addr_q;
    wptr_d      = wr_en ? (wptr_q + c_ONE) : wptr_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (arm) begin
          pre_d   = pretrig_cnt;
          cnt_d   = '0;
          state_d = (pretrig_cnt == '0) ? ST_WAIT_TRIG : ST_PRE;
        end
      end
      ST_PRE: begin
        if (wr_en) begin
          cnt_d = cnt_q + c_ONE;
          if (cnt_d == pre_q) begin
            state_d = ST_WAIT_TRIG;
          end
        end
      end
      ST_WAIT_TRIG: begin
        // The trigger sample itself lands at wptr, so the window start is pre behind it.
        if (wr_en && s_trig_q) begin
          trig_addr_d = wptr_q;
          start_d     = wptr_q - pre_q;
          post_d      = c_LAST_IDX - pre_q;
          state_d     = (post_d == '0) ? ST_DONE : ST_POST;
        end
      end
      ST_POST: begin
        if (wr_en) begin
          post_d = post_q - c_ONE;
          if (post_q == c_ONE) begin
            state_d = ST_DONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    wait_trig = 1'b0;
    done      = 1'b0;
    case (state_q)
      ST_PRE:       busy = 1'b1;
      ST_WAIT_TRIG: begin
        busy      = 1'b1;
        wait_trig = 1'b1;
      end
      ST_POST:      busy = 1'b1;
      ST_DONE:      done = 1'b1;
      default:      ;
    endcase
  end

  ila_sdp_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_en && !reset),
    .waddr_i (wptr_q),
    .wdata_i (s_di_q),
    .re_i    (rd_en),
    .raddr_i (rd_phys),
    .rdata_o (ram_rdata)
  );

  assign trig_addr = trig_addr_q;
  assign do_valid  = rd_valid_q;
  // The RAM read register carries no reset; gating keeps do at zero outside valid cycles.
  assign do_o      = rd_valid_q ? ram_rdata : '0;

endmodule

`default_nettype wire
